// File: rtl/wait_state_mem_responder.sv
// Word-wide data-memory responder with programmable wait states before ack.
// Define MEMRESP_STATS_EN to add saturating rd_count/wr_count outputs.
module wait_state_mem_responder #(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned WAIT_CYCLES = 2,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        clrn,
    input  logic        req,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [3:0]  be,
    output logic [31:0] rdata,
    output logic        ack,
    output logic        err,
    output logic        busy
`ifdef MEMRESP_STATS_EN
    ,
    output logic [15:0] rd_count,
    output logic [15:0] wr_count
`endif
);

    localparam int unsigned AW = $clog2(DEPTH_WORDS);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    logic [1:0]    state;
    logic [3:0]    cnt;
    logic          we_q;
    logic          bad_q;
    logic [AW-1:0] idx_q;
    logic [31:0]   wdata_q;
    logic [3:0]    be_q;
    logic [31:0]   rbuf;

    logic [31:0]   mem [DEPTH_WORDS];

    logic [31:0]   off;
    logic [AW-1:0] idx_in;
    logic          bad_in;
    logic          commit;
    logic          do_write;

    // BASE_ADDR is aligned, so the low offset bits equal addr[1:0]
    always_comb begin
        off    = addr - BASE_ADDR;
        idx_in = off[AW+1:2];
        bad_in = (off[1:0] != 2'b00) || (off[31:AW+2] != '0);
    end

    always_comb begin
        commit   = (state == S_WAIT) && (cnt == 4'd0);
        do_write = commit && we_q && !bad_q;
    end

    assign busy = (state != S_IDLE);

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state   <= S_IDLE;
            cnt     <= '0;
            we_q    <= 1'b0;
            bad_q   <= 1'b0;
            idx_q   <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            rbuf    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req) begin
                        we_q    <= we;
                        bad_q   <= bad_in;
                        idx_q   <= idx_in;
                        wdata_q <= wdata;
                        be_q    <= be;
                        cnt     <= 4'(WAIT_CYCLES);
                        state   <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (cnt == 4'd0) begin
                        rbuf  <= (!we_q && !bad_q) ? mem[idx_q] : '0;
                        state <= S_RESP;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                S_RESP:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    // Response is registered off RESP, so it appears in the following cycle
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            ack   <= 1'b0;
            err   <= 1'b0;
            rdata <= '0;
        end else begin
            ack   <= (state == S_RESP);
            err   <= (state == S_RESP) && bad_q;
            rdata <= (state == S_RESP) ? rbuf : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (do_write) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (be_q[i]) begin
                    mem[idx_q][8*i +: 8] <= wdata_q[8*i +: 8];
                end
            end
        end
    end

`ifdef MEMRESP_STATS_EN
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            rd_count <= '0;
            wr_count <= '0;
        end else if ((state == S_RESP) && !bad_q) begin
            if (we_q) begin
                if (wr_count != 16'hFFFF) wr_count <= wr_count + 16'd1;
            end else begin
                if (rd_count != 16'hFFFF) rd_count <= rd_count + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_wait_state_mem_responder.sv
// Scoreboard bench for wait_state_mem_responder (WAIT_CYCLES=2, DEPTH_WORDS=256).
module tb_wait_state_mem_responder;

    localparam int unsigned WC = 2;

    logic        clk = 1'b0;
    logic        clrn;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] rdata;
    logic        ack;
    logic        err;
    logic        busy;
`ifdef MEMRESP_STATS_EN
    logic [15:0] rd_count;
    logic [15:0] wr_count;
`endif

    wait_state_mem_responder #(
        .DEPTH_WORDS(256),
        .WAIT_CYCLES(WC),
        .BASE_ADDR  (32'h0000_0000)
    ) dut (
        .clk  (clk),
        .clrn (clrn),
        .req  (req),
        .we   (we),
        .addr (addr),
        .wdata(wdata),
        .be   (be),
        .rdata(rdata),
        .ack  (ack),
        .err  (err),
        .busy (busy)
`ifdef MEMRESP_STATS_EN
        ,
        .rd_count(rd_count),
        .wr_count(wr_count)
`endif
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] d;
        logic        e;
        int unsigned c;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    int   exp_rd = 0;
    int   exp_wr = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Monitor: every ack pops one expectation; rdata must be 0 outside ack
    always @(negedge clk) begin
        if (ack) begin
            if (sb.size() == 0) begin
                check("unexpected_ack", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("ack_rdata", rdata, e.d);
                check("ack_err", {31'd0, err}, {31'd0, e.e});
                check("ack_cycle", cyc, e.c);
            end
        end else begin
            check("idle_rdata", rdata, 32'd0);
            check("idle_err", {31'd0, err}, 32'd0);
        end
    end

    task automatic wait_drain();
        for (int i = 0; i < 40 && sb.size() != 0; i++) @(posedge clk);
        if (sb.size() != 0) begin
            check("ack_timeout", sb.size(), 32'd0);
            sb.delete();
        end
        @(posedge clk);
        #1;
    endtask

    // Entered just after an edge with the DUT idle; returns the same way
    task automatic txn(input logic w, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] b, input logic [31:0] exp_d, input logic exp_e);
        exp_t e;
        we = w; addr = a; wdata = d; be = b; req = 1'b1;
        @(posedge clk);
        #1;
        req = 1'b0; we = 1'($urandom); addr = $urandom; wdata = $urandom; be = 4'($urandom);
        e.d = exp_d; e.e = exp_e; e.c = cyc + WC + 2;
        sb.push_back(e);
        if (!exp_e) begin
            if (w) exp_wr++;
            else   exp_rd++;
        end
        wait_drain();
    endtask

    initial begin
        exp_t e;
        int unsigned n;

        clrn = 1'b0; req = 1'b0; we = 1'b0; addr = '0; wdata = '0; be = '0;
        #3;
        check("rst_ack", {31'd0, ack}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_rdata", rdata, 32'd0);
        @(posedge clk); @(posedge clk); #1;
        clrn = 1'b1;
        @(posedge clk); #1;

        // Seed 0x10, then abort a second store to it mid-WAIT
        txn(1'b1, 32'h10, 32'hCAFEF00D, 4'hF, 32'h0, 1'b0);
        we = 1'b1; addr = 32'h10; wdata = 32'h12345678; be = 4'hF; req = 1'b1;
        @(posedge clk); #1;
        req = 1'b0;
        @(posedge clk); #1;
        check("busy_mid_wait", {31'd0, busy}, 32'd1);
        clrn = 1'b0;
        #1;
        check("busy_after_reset", {31'd0, busy}, 32'd0);
        @(posedge clk); #1;
        clrn = 1'b1;
        exp_rd = 0; exp_wr = 0;
        repeat (8) @(posedge clk);
        #1;
        check("no_ack_after_abort", sb.size(), 32'd0);
        txn(1'b0, 32'h10, 32'h0, 4'hF, 32'hCAFEF00D, 1'b0);

        // Full-word store/load and byte merge
        txn(1'b1, 32'h08, 32'hDEADBEEF, 4'hF, 32'h0, 1'b0);
        txn(1'b0, 32'h08, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0);
        txn(1'b1, 32'h08, 32'h11223344, 4'b0101, 32'h0, 1'b0);
        txn(1'b0, 32'h08, 32'h0, 4'hF, 32'hDE22BE44, 1'b0);
        txn(1'b1, 32'h08, 32'hFFFFFFFF, 4'b0000, 32'h0, 1'b0);
        txn(1'b0, 32'h08, 32'h0, 4'hF, 32'hDE22BE44, 1'b0);

        // Error accesses leave RAM untouched (0x400 would alias word 0)
        txn(1'b1, 32'h00, 32'h0BADC0DE, 4'hF, 32'h0, 1'b0);
        txn(1'b0, 32'h06, 32'h0, 4'hF, 32'h0, 1'b1);
        txn(1'b0, 32'h400, 32'h0, 4'hF, 32'h0, 1'b1);
        txn(1'b1, 32'h400, 32'hFFFFFFFF, 4'hF, 32'h0, 1'b1);
        txn(1'b1, 32'h0A, 32'h00000000, 4'hF, 32'h0, 1'b1);
        txn(1'b0, 32'h00, 32'h0, 4'hF, 32'h0BADC0DE, 1'b0);
        txn(1'b0, 32'h08, 32'h0, 4'hF, 32'hDE22BE44, 1'b0);

        // Back-to-back: req held high, accepts at n, n+5, n+10
        we = 1'b0; be = 4'hF; addr = 32'h08; req = 1'b1;
        @(posedge clk); #1;
        n = cyc;
        e.d = 32'hDE22BE44; e.e = 1'b0; e.c = n + 4; sb.push_back(e);
        addr = 32'h10;
        for (int unsigned k = 1; k <= 10; k++) begin
            @(posedge clk); #1;
            if (k == 3 || k == 5 || k == 8 || k == 10)
                check("b2b_busy_high", {31'd0, busy}, 32'd1);
            if (k == 4 || k == 9)
                check("b2b_busy_bubble", {31'd0, busy}, 32'd0);
            if (k == 5) begin
                e.d = 32'hCAFEF00D; e.e = 1'b0; e.c = n + 9; sb.push_back(e);
                addr = 32'h00;
            end
            if (k == 10) begin
                e.d = 32'h0BADC0DE; e.e = 1'b0; e.c = n + 14; sb.push_back(e);
                req = 1'b0;
            end
        end
        exp_rd += 3;
        wait_drain();
        repeat (6) @(posedge clk);
        #1;
        check("no_extra_accept", {31'd0, busy}, 32'd0);

`ifdef MEMRESP_STATS_EN
        check("rd_count", {16'd0, rd_count}, 32'(exp_rd));
        check("wr_count", {16'd0, wr_count}, 32'(exp_wr));
        force dut.rd_count = 16'hFFFE;
        @(posedge clk); #1;
        release dut.rd_count;
        txn(1'b0, 32'h08, 32'h0, 4'hF, 32'hDE22BE44, 1'b0);
        check("rd_count_max", {16'd0, rd_count}, 32'h0000FFFF);
        txn(1'b0, 32'h08, 32'h0, 4'hF, 32'hDE22BE44, 1'b0);
        check("rd_count_sat", {16'd0, rd_count}, 32'h0000FFFF);
`endif

        check("scoreboard_empty", sb.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
